lfsr_encrypt_ctrl: RTL and testbench

Hardware sequencer for the LFSR message-encryption task, replacing the behavioural bench DUT with synthesizable control. It starts on the Req handshake and reads three configuration bytes from data memory: seed, tap index and pad-space count. It then walks the 64-byte output window, issuing one memory read and one memory write per byte, and asserts Ack when done. It is the sole master of the DataMem port during a run and sits between top_level's Req/Ack and DataMem.

---
 rtl/lfsr_ctrl_pkg.sv | 54 +++++
 rtl/lfsr7_step.sv | 20 ++
 rtl/lfsr_encrypt_ctrl.sv | 147 ++++++++++++++
 tb/tb_lfsr_encrypt_ctrl.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lfsr_ctrl_pkg.sv
// lfsr_ctrl_pkg
// Shared definitions for the LFSR message-encryption sequencer:
//   - state_e      : sequencer state encoding
//   - TAP_TABLE    : 9-entry feedback tap table, selected by the tap-index byte
//   - PAD_CHAR     : plaintext used for the leading pad positions
//   - address map  : message, configuration and output locations in DataMem
//   - tap_lookup   : tap-index byte -> taps (out-of-range indices select entry 0)
//   - rd_addr      : plaintext read address for output byte idx
// Optional feature macro (used by the top): LFSR_CTRL_PARITY_EN
package lfsr_ctrl_pkg;

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_LD_SEED   = 3'd1,
        S_LD_TAPIDX = 3'd2,
        S_LD_SPACES = 3'd3,
        S_RD        = 3'd4,
        S_WR        = 3'd5,
        S_DONE      = 3'd6
    } state_e;

    localparam logic [7:0] MSG_BASE        = 8'd0;
    localparam logic [7:0] CFG_SEED_ADDR   = 8'd63;
    localparam logic [7:0] CFG_TAPIDX_ADDR = 8'd62;
    localparam logic [7:0] CFG_SPACES_ADDR = 8'd61;
    localparam logic [7:0] OUT_BASE        = 8'd64;
    localparam logic [6:0] MSG_LEN         = 7'd64;

    localparam logic [6:0] PAD_CHAR = 7'h20;

    localparam int TAP_TABLE_SIZE = 9;
    // Every entry fits in 7 bits, so only the LFSR-relevant bits are stored.
    localparam logic [6:0] TAP_TABLE [0:TAP_TABLE_SIZE-1] = '{
        7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B
    };

    function automatic logic [6:0] tap_lookup(input logic [7:0] idx);
        logic [6:0] entry;
        entry = TAP_TABLE[0];
        if (idx < 8'(TAP_TABLE_SIZE)) begin
            entry = TAP_TABLE[idx[3:0]];
        end
        return entry;
    endfunction

    // Pad positions never touch memory; their address is parked at 0.
    function automatic logic [7:0] rd_addr(input logic [6:0] idx, input logic [6:0] spaces);
        if (idx < spaces) begin
            return 8'd0;
        end
        return MSG_BASE + {1'b0, idx - spaces};
    endfunction

endpackage

// File: rtl/lfsr7_step.sv
// lfsr7_step
// Combinational 7-bit Fibonacci LFSR step plus a 7-bit parity tree.
// Ports:
//   state_i  [6:0] in   current LFSR state
//   taps_i   [6:0] in   feedback taps
//   word_i   [6:0] in   word whose parity is reported
//   next_o   [6:0] out  {state_i[5:0], ^(state_i & taps_i)}; old MSB is dropped
//   parity_o       out  XOR-reduction of word_i
module lfsr7_step (
    input  logic [6:0] state_i,
    input  logic [6:0] taps_i,
    input  logic [6:0] word_i,
    output logic [6:0] next_o,
    output logic       parity_o
);

    assign next_o   = {state_i[5:0], ^(state_i & taps_i)};
    assign parity_o = ^word_i;

endmodule

// File: rtl/lfsr_encrypt_ctrl.sv
// lfsr_encrypt_ctrl
// Sequencer for the LFSR message-encryption task. A falling edge of Req
// (seen in IDLE or DONE) starts a run: seed, tap index and pad-space count
// are read from DataMem, then MSG_LEN ciphertext bytes are produced with one
// read cycle and one write cycle each, and Ack is raised until Req goes high.
// Req high in any state aborts to IDLE; bytes already written stay written.
// Ports:
//   Clk            in   clock, rising edge
//   Reset          in   asynchronous active-high reset
//   Req            in   start (falling edge) / abort (high) from host
//   Ack            out  run complete, held until Req high
//   MemAddr  [7:0] out  DataMem address (registered)
//   MemWrEn        out  DataMem write enable, one-cycle pulse per byte
//   MemWrData[7:0] out  DataMem write data {P, lfsr ^ plain}
//   MemRdData[7:0] in   DataMem read data, combinational from MemAddr
//   DbgState       out  current sequencer state
// Optional feature: define LFSR_CTRL_PARITY_EN to put the parity of the
// ciphertext in MemWrData[7]; otherwise bit 7 is always 0.
//
// Handshake: all outputs are registered; the address for a state is loaded on
// the edge that enters that state, so MemRdData is valid throughout the state.
module lfsr_encrypt_ctrl
    import lfsr_ctrl_pkg::*;
(
    input  logic       Clk,
    input  logic       Reset,
    input  logic       Req,
    output logic       Ack,
    output logic [7:0] MemAddr,
    output logic       MemWrEn,
    output logic [7:0] MemWrData,
    input  logic [7:0] MemRdData,
    output state_e     DbgState
);

    state_e     state_q;
    logic       req_q;
    logic [6:0] lfsr_q;
    logic [6:0] taps_q;
    logic [6:0] spaces_q;
    logic [6:0] idx_q;

    logic [6:0] spaces_d;
    logic [6:0] plain_d;
    logic [6:0] cipher_d;
    logic [6:0] lfsr_d;
    logic [6:0] par_word;
    logic       par_bit;
    logic       start_evt;
    logic       last_byte;

    assign start_evt = req_q && !Req && (state_q == S_IDLE || state_q == S_DONE);
    assign spaces_d  = (MemRdData > {1'b0, MSG_LEN}) ? MSG_LEN : MemRdData[6:0];
    assign plain_d   = (idx_q < spaces_q) ? PAD_CHAR : MemRdData[6:0];
    assign cipher_d  = lfsr_q ^ plain_d;
    assign last_byte = (idx_q == MSG_LEN - 7'd1);

`ifdef LFSR_CTRL_PARITY_EN
    assign par_word = cipher_d;
`else
    // A constant word folds the parity tree away and forces bit 7 to 0.
    assign par_word = 7'd0;
`endif

    lfsr7_step u_step (
        .state_i  (lfsr_q),
        .taps_i   (taps_q),
        .word_i   (par_word),
        .next_o   (lfsr_d),
        .parity_o (par_bit)
    );

    assign DbgState = state_q;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q   <= S_IDLE;
            req_q     <= 1'b0;
            lfsr_q    <= 7'd0;
            taps_q    <= 7'd0;
            spaces_q  <= 7'd0;
            idx_q     <= 7'd0;
            Ack       <= 1'b0;
            MemAddr   <= 8'd0;
            MemWrEn   <= 1'b0;
            MemWrData <= 8'd0;
        end else begin
            req_q   <= Req;
            MemWrEn <= 1'b0;
            if (Req) begin
                state_q <= S_IDLE;
                Ack     <= 1'b0;
                MemAddr <= 8'd0;
            end else begin
                case (state_q)
                    S_IDLE, S_DONE: begin
                        if (start_evt) begin
                            state_q <= S_LD_SEED;
                            Ack     <= 1'b0;
                            idx_q   <= 7'd0;
                            MemAddr <= CFG_SEED_ADDR;
                        end
                    end
                    S_LD_SEED: begin
                        lfsr_q  <= MemRdData[6:0];
                        state_q <= S_LD_TAPIDX;
                        MemAddr <= CFG_TAPIDX_ADDR;
                    end
                    S_LD_TAPIDX: begin
                        taps_q  <= tap_lookup(MemRdData);
                        state_q <= S_LD_SPACES;
                        MemAddr <= CFG_SPACES_ADDR;
                    end
                    S_LD_SPACES: begin
                        // Clipped count is needed now to address byte 0.
                        spaces_q <= spaces_d;
                        state_q  <= S_RD;
                        MemAddr  <= rd_addr(7'd0, spaces_d);
                    end
                    S_RD: begin
                        state_q   <= S_WR;
                        MemAddr   <= OUT_BASE + {1'b0, idx_q};
                        MemWrEn   <= 1'b1;
                        MemWrData <= {par_bit, cipher_d};
                    end
                    S_WR: begin
                        lfsr_q <= lfsr_d;
                        idx_q  <= idx_q + 7'd1;
                        if (last_byte) begin
                            state_q <= S_DONE;
                            Ack     <= 1'b1;
                            MemAddr <= 8'd0;
                        end else begin
                            state_q <= S_RD;
                            MemAddr <= rd_addr(idx_q + 7'd1, spaces_q);
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        MemAddr <= 8'd0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_lfsr_encrypt_ctrl.sv
// tb_lfsr_encrypt_ctrl
// Bench for lfsr_encrypt_ctrl: a behavioural DataMem, a write monitor that
// checks every write against an expected queue, a table of directed runs with
// hand-computed first output bytes, and sequences for abort and async reset.
// Honours LFSR_CTRL_PARITY_EN for the expected value of bit 7.
module tb_lfsr_encrypt_ctrl;
    import lfsr_ctrl_pkg::*;

`ifdef LFSR_CTRL_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    localparam int ACK_EDGES = 132;

    logic       Clk;
    logic       Reset;
    logic       Req;
    logic       Ack;
    logic [7:0] MemAddr;
    logic       MemWrEn;
    logic [7:0] MemWrData;
    logic [7:0] MemRdData;
    state_e     DbgState;

    logic [7:0] mem [0:255];
    logic [7:0] exp_q [$];
    logic [7:0] exp_addr_q [$];

    int errors;
    int checks;
    int wr_count;
    int bad_rd;
    bit pad_only;

    typedef struct {
        logic [7:0] seed;
        logic [7:0] idx;
        logic [7:0] spaces;
        logic [7:0] p0;
        logic [7:0] p1;
        logic [7:0] e0;
        logic [7:0] e1;
        logic [7:0] e2;
        bit         chk2;
        bit         pad_only;
    } vec_t;

    vec_t vecs [0:6];

    lfsr_encrypt_ctrl dut (
        .Clk       (Clk),
        .Reset     (Reset),
        .Req       (Req),
        .Ack       (Ack),
        .MemAddr   (MemAddr),
        .MemWrEn   (MemWrEn),
        .MemWrData (MemWrData),
        .MemRdData (MemRdData),
        .DbgState  (DbgState)
    );

    // ---------------- clock / reset / memory ----------------
    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    assign MemRdData = mem[MemAddr];

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- checking helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] with_par(input logic [7:0] v);
        return PAR_EN ? v : (v & 8'h7F);
    endfunction

    // Reference model of one full run, built from the current memory image.
    task automatic build_expected(input logic [7:0] seed, input logic [7:0] idx, input logic [7:0] spaces);
        logic [6:0] tb_taps [0:8];
        logic [6:0] l;
        logic [6:0] t;
        logic [6:0] p;
        logic [6:0] c;
        int         s;
        tb_taps = '{7'h60, 7'h48, 7'h78, 7'h72, 7'h6A, 7'h69, 7'h5C, 7'h7E, 7'h7B};
        l = seed[6:0];
        t = (idx <= 8'd8) ? tb_taps[idx[3:0]] : 7'h60;
        s = (spaces > 8'd64) ? 64 : int'(spaces);
        exp_q.delete();
        exp_addr_q.delete();
        for (int i = 0; i < 64; i++) begin
            p = (i < s) ? 7'h20 : mem[i - s][6:0];
            c = l ^ p;
            exp_q.push_back({PAR_EN ? ^c : 1'b0, c});
            exp_addr_q.push_back(8'(64 + i));
            l = {l[5:0], ^(l & t)};
        end
    endtask

    // ---------------- write monitor / scoreboard ----------------
    always @(negedge Clk) begin
        if (MemWrEn) begin
            logic [7:0] e;
            logic [7:0] ea;
            wr_count++;
            mem[MemAddr] = MemWrData;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: got addr 0x%0h data 0x%0h, expected no write", MemAddr, MemWrData);
            end else begin
                e  = exp_q.pop_front();
                ea = exp_addr_q.pop_front();
                check("wr_data", 32'(MemWrData), 32'(e));
                check("wr_addr", 32'(MemAddr), 32'(ea));
            end
        end
        if (pad_only && DbgState == S_RD && MemAddr != 8'd0) begin
            bad_rd++;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic setup_mem(input vec_t v);
        for (int k = 0; k < 256; k++) begin
            mem[k] = 8'($urandom_range(0, 255));
        end
        mem[0]  = v.p0;
        mem[1]  = v.p1;
        mem[61] = v.spaces;
        mem[62] = v.idx;
        mem[63] = v.seed;
    endtask

    // Leaves Req low just before the edge that detects the start.
    task automatic start_run();
        @(negedge Clk);
        Req = 1'b1;
        @(negedge Clk);
        Req = 1'b0;
    endtask

    // Counts edges from the detecting edge (edge 1) until Ack is seen high.
    task automatic wait_done(input string name);
        int edges;
        edges = 0;
        while (edges < 300) begin
            @(posedge Clk);
            edges++;
            #1;
            if (Ack) break;
        end
        check(name, 32'(edges), 32'(ACK_EDGES));
        @(negedge Clk);
    endtask

    // ---------------- test ----------------
    initial begin
        errors   = 0;
        checks   = 0;
        wr_count = 0;
        bad_rd   = 0;
        pad_only = 1'b0;
        Reset    = 1'b1;
        Req      = 1'b0;
        for (int k = 0; k < 256; k++) mem[k] = 8'h00;

        //            seed   idx    sp     p0     p1     e0     e1     e2     chk2 pad
        vecs[0] = '{8'h01, 8'h00, 8'h00, 8'h41, 8'h42, 8'hC0, 8'hC0, 8'h00, 1'b0, 1'b0};
        vecs[1] = '{8'h01, 8'h00, 8'h02, 8'h41, 8'h42, 8'h21, 8'h22, 8'hC5, 1'b1, 1'b0};
        vecs[2] = '{8'h60, 8'h00, 8'h00, 8'h00, 8'h00, 8'h60, 8'hC0, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'h01, 8'h09, 8'hC8, 8'h33, 8'h44, 8'h21, 8'h22, 8'h00, 1'b0, 1'b1};
        vecs[4] = '{8'h81, 8'h01, 8'h00, 8'hC1, 8'h02, 8'hC0, 8'h00, 8'h00, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 8'h03, 8'h00, 8'h7F, 8'h55, 8'hFF, 8'h55, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'h7F, 8'h07, 8'h01, 8'h00, 8'h11, 8'h5F, 8'h7E, 8'h00, 1'b0, 1'b0};

        // Reset state
        #2;
        check("rst_ack",    32'(Ack),       32'd0);
        check("rst_wren",   32'(MemWrEn),   32'd0);
        check("rst_addr",   32'(MemAddr),   32'd0);
        check("rst_wrdata", 32'(MemWrData), 32'd0);
        check("rst_state",  32'(DbgState),  32'(S_IDLE));
        repeat (2) @(negedge Clk);
        Reset = 1'b0;
        repeat (2) @(negedge Clk);

        // Table of directed runs
        for (int v = 0; v < 7; v++) begin
            setup_mem(vecs[v]);
            build_expected(vecs[v].seed, vecs[v].idx, vecs[v].spaces);
            pad_only = vecs[v].pad_only;
            bad_rd   = 0;
            start_run();
            wait_done("ack_latency");
            check("exp_left", 32'(exp_q.size()), 32'd0);
            check("out0", 32'(mem[64]), 32'(with_par(vecs[v].e0)));
            check("out1", 32'(mem[65]), 32'(with_par(vecs[v].e1)));
            if (vecs[v].chk2) check("out2", 32'(mem[66]), 32'(with_par(vecs[v].e2)));
            if (vecs[v].pad_only) check("pad_no_msg_read", 32'(bad_rd), 32'd0);
            pad_only = 1'b0;
            repeat (5) @(negedge Clk);
            check("ack_held", 32'(Ack), 32'd1);
            check("done_wren", 32'(MemWrEn), 32'd0);
        end

        // Abort at cycle 40, then a clean restart
        setup_mem(vecs[0]);
        build_expected(vecs[0].seed, vecs[0].idx, vecs[0].spaces);
        wr_count = 0;
        start_run();
        repeat (40) @(posedge Clk);
        @(negedge Clk);
        Req = 1'b1;
        @(posedge Clk);
        #1;
        check("abort_state", 32'(DbgState), 32'(S_IDLE));
        check("abort_ack",   32'(Ack),      32'd0);
        check("abort_wren",  32'(MemWrEn),  32'd0);
        check("abort_writes", 32'(wr_count), 32'd18);
        repeat (10) @(negedge Clk);
        check("abort_quiet", 32'(wr_count), 32'd18);
        build_expected(vecs[0].seed, vecs[0].idx, vecs[0].spaces);
        Req = 1'b0;
        wait_done("restart_latency");
        check("restart_exp_left", 32'(exp_q.size()), 32'd0);
        check("restart_out0", 32'(mem[64]), 32'(with_par(8'hC0)));

        // Asynchronous reset in the middle of a write cycle
        setup_mem(vecs[1]);
        build_expected(vecs[1].seed, vecs[1].idx, vecs[1].spaces);
        start_run();
        begin
            bit seen;
            seen = 1'b0;
            for (int k = 0; k < 20 && !seen; k++) begin
                @(posedge Clk);
                #1;
                if (MemWrEn) seen = 1'b1;
            end
            check("wr_seen", 32'(seen), 32'd1);
        end
        #2;
        Reset = 1'b1;
        #1;
        check("arst_wren",   32'(MemWrEn),   32'd0);
        check("arst_state",  32'(DbgState),  32'(S_IDLE));
        check("arst_addr",   32'(MemAddr),   32'd0);
        check("arst_wrdata", 32'(MemWrData), 32'd0);
        exp_q.delete();
        exp_addr_q.delete();
        @(negedge Clk);
        Reset = 1'b0;

        // Asynchronous reset while Ack is held in DONE
        setup_mem(vecs[2]);
        build_expected(vecs[2].seed, vecs[2].idx, vecs[2].spaces);
        start_run();
        wait_done("ack_latency_pre_rst");
        @(posedge Clk);
        #2;
        Reset = 1'b1;
        #1;
        check("arst_ack", 32'(Ack), 32'd0);
        @(negedge Clk);
        Reset = 1'b0;
        repeat (3) @(posedge Clk);
        #1;
        check("no_spurious_start", 32'(DbgState), 32'(S_IDLE));

        // Fresh run after reset
        @(negedge Clk);
        setup_mem(vecs[6]);
        build_expected(vecs[6].seed, vecs[6].idx, vecs[6].spaces);
        start_run();
        wait_done("post_rst_latency");
        check("post_rst_out1", 32'(mem[65]), 32'(with_par(8'h7E)));
        check("post_rst_exp_left", 32'(exp_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
